// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if
//   Bundles the buffer-write, control and result signals of the convolution
//   multiply-accumulate stage.
//   master : testbench / upstream side (drives writes, start, pix_addr)
//   slave  : conv_window_mac side (drives busy, result, valid, err)
interface conv_window_mac_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 11
);
  logic              pix_we;
  logic [3:0]        pix_waddr;
  logic [DATA_W-1:0] pix_wdata;
  logic              k_we;
  logic [3:0]        k_waddr;
  logic [DATA_W-1:0] k_wdata;
  logic              start;
  logic [3:0]        pix_addr;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              valid;
  logic              err;

  modport master (
    output pix_we, pix_waddr, pix_wdata, k_we, k_waddr, k_wdata, start, pix_addr,
    input  busy, result, valid, err
  );

  modport slave (
    input  pix_we, pix_waddr, pix_wdata, k_we, k_waddr, k_wdata, start, pix_addr,
    output busy, result, valid, err
  );
endinterface

// File: rtl/conv_window_mac.sv
// conv_window_mac
//   Multiply-accumulate stage of the 4x4 image convolution datapath. Holds a
//   16-entry pixel buffer and a 9-entry kernel buffer, follows the upstream
//   window counter's address stream and accumulates the nine products of the
//   3x3 window at addresses 5,6,7,9,10,11,13,14,15 into one result.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : conv_window_mac_if.slave
//            pix_we/pix_waddr/pix_wdata : pixel buffer write (IDLE only)
//            k_we/k_waddr/k_wdata       : kernel buffer write (IDLE only, index 0..8)
//            start                      : request a window pass (sampled in IDLE)
//            pix_addr                   : upstream window address stream
//            busy                       : high in ARM and ACC
//            result                     : last completed sum, held
//            valid                      : one-cycle pulse when result updates
//            err                        : one-cycle pulse on an address-sequence violation
module conv_window_mac #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 11
) (
  input logic             CLK,
  input logic             RESET,
  conv_window_mac_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_ACC  = 2'b10;

  logic [1:0]        state_r;
  logic [3:0]        tap_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  result_r;
  logic              valid_r;
  logic              err_r;
  logic              busy_r;
  logic [DATA_W-1:0] pix_mem_r  [0:15];
  logic [DATA_W-1:0] kern_mem_r [0:8];

  logic [3:0]        exp_addr_s;
  logic              addr_hit_s;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  prod_ext_s;
  logic [ACC_W-1:0]  sum_s;

  // Window address expected for a given tap: row = tap/3, col = tap%3, both
  // offset by one into the 4x4 image, i.e. {row+1, col+1}.
  function automatic logic [3:0] tap_addr(input logic [3:0] tap);
    logic [3:0] a;
    case (tap)
      4'd0:    a = 4'd5;
      4'd1:    a = 4'd6;
      4'd2:    a = 4'd7;
      4'd3:    a = 4'd9;
      4'd4:    a = 4'd10;
      4'd5:    a = 4'd11;
      4'd6:    a = 4'd13;
      4'd7:    a = 4'd14;
      4'd8:    a = 4'd15;
      default: a = 4'd0;
    endcase
    return a;
  endfunction

  // Product of the addressed pixel and the current tap's weight. Only used
  // when pix_addr matches tap_r's address, so kern[tap_r] is the weight the
  // address itself maps to.
  always_comb begin
    exp_addr_s = tap_addr(tap_r);
    addr_hit_s = (bus.pix_addr == exp_addr_s);
    prod_s     = {{(PROD_W-DATA_W){1'b0}}, pix_mem_r[bus.pix_addr]} *
                 {{(PROD_W-DATA_W){1'b0}}, kern_mem_r[tap_r]};
    prod_ext_s = {{(ACC_W-PROD_W){1'b0}}, prod_s};
    sum_s      = acc_r + prod_ext_s;
  end

  // Pixel and kernel buffers; writes are accepted only while idle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) pix_mem_r[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < 9; i++)  kern_mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE && bus.pix_we) begin
        pix_mem_r[bus.pix_waddr] <= bus.pix_wdata;
      end
      if (state_r == ST_IDLE && bus.k_we && bus.k_waddr <= 4'd8) begin
        kern_mem_r[bus.k_waddr] <= bus.k_wdata;
      end
    end
  end

  // Pass control FSM, accumulator and registered result/status outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r  <= ST_IDLE;
      tap_r    <= 4'd0;
      acc_r    <= {ACC_W{1'b0}};
      result_r <= {ACC_W{1'b0}};
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_ARM;
            busy_r  <= 1'b1;
          end
        end
        ST_ARM: begin
          // Wait for the counter to reach the window origin; everything else
          // (including its post-reset 0) is skipped.
          if (bus.pix_addr == 4'd5) begin
            acc_r   <= prod_ext_s;
            tap_r   <= 4'd1;
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (addr_hit_s) begin
            if (tap_r == 4'd8) begin
              result_r <= sum_s;
              valid_r  <= 1'b1;
              acc_r    <= {ACC_W{1'b0}};
              tap_r    <= 4'd0;
              state_r  <= ST_IDLE;
              busy_r   <= 1'b0;
            end else begin
              acc_r <= sum_s;
              tap_r <= tap_r + 4'd1;
            end
          end else begin
            // Out-of-order address: drop the partial sum, keep old result.
            err_r   <= 1'b1;
            acc_r   <= {ACC_W{1'b0}};
            tap_r   <= 4'd0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          acc_r   <= {ACC_W{1'b0}};
          tap_r   <= 4'd0;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.result = result_r;
  assign bus.valid  = valid_r;
  assign bus.err    = err_r;

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Multiply-accumulate stage of the 4x4, 4-bit image convolution datapath. It sits directly downstream of the nine-state window address counter. It holds a 16-entry pixel buffer and a 9-entry kernel buffer, and consumes the counter's 4-bit pixel address stream. Each armed pass accumulates the nine pixel×weight products of the 3x3 window at addresses 5,6,7,9,10,11,13,14,15 and emits one 11-bit result with a one-cycle valid pulse.

## Interface
- DATA_W, 4: pixel and kernel weight width, unsigned.
- ACC_W, 11: accumulator/result width; 9×15×15 = 2025 fits without overflow.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset (clears state while 0).
- pix_we  input  1  pixel buffer write strobe.
- pix_waddr  input  4  pixel buffer write address, 0..15.
- pix_wdata  input  DATA_W  pixel write data.
- k_we  input  1  kernel buffer write strobe.
- k_waddr  input  4  kernel write index, 0..8; values 9..15 are ignored.
- k_wdata  input  DATA_W  kernel weight write data.
- start  input  1  request one window pass; sampled only in IDLE.
- pix_addr  input  4  address stream from the upstream window counter.
- busy  output  1  high in ARM and ACC.
- result  output  ACC_W  last completed sum; held until the next completion.
- valid  output  1  one-cycle pulse when result updates.
- err  output  1  one-cycle pulse on an address-sequence violation.

## Operation
- Reset (RESET=0, asynchronous): state=IDLE; tap=0; acc=0; result=0; valid=0; err=0; busy=0. All pixel and kernel entries are cleared to 0.
- Buffer writes take effect on the edge when the strobe is high and state is IDLE. Writes in ARM or ACC are dropped. Pixel and kernel writes in the same cycle are both performed.
- Tap mapping: row = pix_addr[3:2]−1, col = pix_addr[1:0]−1, tap k = 3·row+col. Expected order: 5→k0, 6→k1, 7→k2, 9→k3, 10→k4, 11→k5, 13→k6, 14→k7, 15→k8.
- Product = pix[pix_addr] × kern[k]. The product is 8 bits and is zero-extended to ACC_W.
- FSM:
  - IDLE: start=1 → ARM. Otherwise stay in IDLE.
  - ARM: pix_addr==5 → acc=product(k0), tap=1 → ACC. Any other address → stay in ARM. The upstream counter's post-reset 0 and the values 10..15,9 are skipped.
  - ACC: if pix_addr equals the expected address for tap, then acc += product and tap++. When tap 8 is added: result = final sum, valid=1 next cycle, tap=0 → IDLE.
  - ACC mismatch: if pix_addr does not equal the expected address, err=1 next cycle, acc is discarded, result is unchanged, tap=0 → IDLE.
- start in ARM or ACC is ignored; there is no queueing.
- Reset asserted mid-pass aborts the pass. No valid or err is produced. Buffers are cleared.

## Timing
- Let cycle A be the first cycle in ARM where pix_addr==5. The accumulation then occupies cycles A..A+8.
- valid=1 and the new result are visible in cycle A+9. busy is low from A+9.
- Start-to-first-tap: start sampled at edge t gives ARM from t+1. With a free-running 9-state counter, the wait in ARM is 0..8 cycles.
- Total latency from start to valid: 10..18 cycles.
- Back-to-back passes: start may be asserted in cycle A+9 (IDLE). The next window cannot begin before the counter's next 5, which is 9 cycles after A.
- valid and err are mutually exclusive and each lasts exactly one cycle.
- result is registered, with no combinational path from pix_addr.

## Test plan
- Pixels all 15, weights all 15; drive start; counter runs from reset (0,10,11,13,14,15,5,6,7,9,10,…) → taps begin at the first 5; valid pulses once with result=2025; busy high for exactly the ARM+ACC cycles.
- Identity kernel (k4=1, others 0), pix[10]=7, all other pixels 9 → result=7.
- Ramp: pix[a]=a; weights k0..k8 = 1..9 → result = 5·1+6·2+7·3+9·4+10·5+11·6+13·7+14·8+15·9 = 528.
- Sequence break: drive 5,6,7 then 8 → err pulses in the cycle after the 8; valid stays 0; result keeps its previous value; a fresh start then completes normally.
- Reset mid-pass: pull RESET low after the tap at address 9 → busy, valid, err and result read 0 immediately; all buffers read back as 0; no pulse after release.
- Writes while busy: pix_we with pix_waddr=6, pix_wdata=3 during ACC → write dropped; the next pass uses the old pix[6]. A k_waddr=12 write in IDLE → no kernel entry changes.
